// File: rtl/traffic_pkg.sv
// Shared phase encoding and default dwell constants for the traffic light FSM
// and its phase timer.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_RED_CYC    = 20;
    localparam int DEF_GREEN_CYC  = 30;
    localparam int DEF_YELLOW_CYC = 5;
    localparam int DEF_GREEN_MIN  = 10;

    // Anything other than exactly one lit lamp is not a phase.
    function automatic phase_e decode_phase(input logic red, input logic yellow,
                                            input logic green);
        phase_e ph;
        case ({red, yellow, green})
            3'b100:  ph = PH_RED;
            3'b010:  ph = PH_YELLOW;
            3'b001:  ph = PH_GREEN;
            default: ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Light FSM <-> phase timer signal bundle. Pedestrian signals exist only
// when PED_REQ_EN is defined.
interface traffic_phase_timer_if;

    logic red;
    logic yellow;
    logic green;
    logic advance;
    logic phase_err;

`ifdef PED_REQ_EN
    logic ped_req;
    logic ped_ack;
    logic walk;

    modport master (output red, yellow, green, ped_req,
                    input  advance, phase_err, ped_ack, walk);
    modport slave  (input  red, yellow, green, ped_req,
                    output advance, phase_err, ped_ack, walk);
`else
    modport master (output red, yellow, green,
                    input  advance, phase_err);
    modport slave  (input  red, yellow, green,
                    output advance, phase_err);
`endif

endinterface

// File: rtl/traffic_phase_timer_ped_req_latch.sv
// Pedestrian request latch: holds a pending request until red entry, acks new
// requests and presents walk for the duration of the following red.
module ped_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    input  logic red_entry,
    input  logic in_red,
    output logic pending,
    output logic ped_ack,
    output logic walk
);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            ped_ack <= 1'b0;
            walk    <= 1'b0;
        end else begin
            ped_ack <= ped_req && !pending;
            // A request arriving on the red entry cycle survives the clear.
            pending <= red_entry ? ped_req : (pending || ped_req);
            if (!in_red)
                walk <= 1'b0;
            else if (red_entry)
                walk <= pending;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase dwell timer: issues one advance strobe per light phase after its
// programmed dwell. Define PED_REQ_EN for pedestrian request / early green.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RED_CYC    = DEF_RED_CYC,
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int GREEN_MIN  = DEF_GREEN_MIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_phase_timer_if.slave  bus
);

    localparam int MAX_CYC = (RED_CYC > GREEN_CYC)
                           ? ((RED_CYC > YELLOW_CYC) ? RED_CYC : YELLOW_CYC)
                           : ((GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC);

    if (RED_CYC < 2 || GREEN_CYC < 2 || YELLOW_CYC < 2) begin : g_bad_dwell
        $error("traffic_phase_timer: every dwell must be at least 2 cycles");
    end
    if (GREEN_MIN < 2 || GREEN_MIN > GREEN_CYC) begin : g_bad_gmin
        $error("traffic_phase_timer: GREEN_MIN must lie in 2..GREEN_CYC");
    end
    if (MAX_CYC - 1 >= (2 ** CNT_W)) begin : g_bad_width
        $error("traffic_phase_timer: CNT_W too narrow for the longest dwell");
    end

    // The registered strobe is decided one cycle early, hence the *_PRE values.
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYC - 1);
    localparam logic [CNT_W-1:0] RED_PRE     = CNT_W'(RED_CYC - 2);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_PRE   = CNT_W'(GREEN_CYC - 2);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_PRE  = CNT_W'(YELLOW_CYC - 2);

    phase_e           phase;
    phase_e           prev_phase;
    logic             entry;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] pre;
    logic             done_q;
    logic             done_eff;
    logic             done_nxt;
    logic             early;
    logic             fire;

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] GMIN_PRE = CNT_W'(GREEN_MIN - 2);

    logic pending;
    logic red_entry;
    logic in_red;

    assign in_red    = (phase == PH_RED);
    assign red_entry = entry && in_red;

    ped_req_latch u_ped_req_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .ped_req   (bus.ped_req),
        .red_entry (red_entry),
        .in_red    (in_red),
        .pending   (pending),
        .ped_ack   (bus.ped_ack),
        .walk      (bus.walk)
    );
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        phase    = decode_phase(bus.red, bus.yellow, bus.green);
        entry    = (phase != prev_phase);
        count    = entry ? '0 : cnt_q;
        done_eff = !entry && done_q;
        last     = '0;
        pre      = '0;
        early    = 1'b0;
        case (phase)
            PH_RED:    begin last = RED_LAST;    pre = RED_PRE;    end
            PH_GREEN:  begin last = GREEN_LAST;  pre = GREEN_PRE;  end
            PH_YELLOW: begin last = YELLOW_LAST; pre = YELLOW_PRE; end
            default:   ;
        endcase
`ifdef PED_REQ_EN
        early = (phase == PH_GREEN) && pending && (count >= GMIN_PRE);
`endif
        fire = (phase != PH_NONE) && !done_eff && ((count == pre) || early);

        // Once the strobe has gone out the count parks until the next entry.
        if (phase == PH_NONE)
            cnt_nxt = '0;
        else if (done_eff || count == last)
            cnt_nxt = count;
        else
            cnt_nxt = count + CNT_W'(1);

        done_nxt = (phase != PH_NONE) && (done_eff || fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_phase    <= PH_NONE;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            bus.advance   <= 1'b0;
            bus.phase_err <= 1'b0;
        end else begin
            prev_phase    <= phase;
            cnt_q         <= cnt_nxt;
            done_q        <= done_nxt;
            bus.advance   <= fire;
            bus.phase_err <= (phase == PH_NONE);
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer: directed scenarios plus a
// randomized light-FSM run against a cycle-timestamp reference model.
module tb_traffic_phase_timer;

    localparam int RC = 4;
    localparam int GC = 6;
    localparam int YC = 2;
    localparam int GM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_timer_if bus ();

    traffic_phase_timer #(
        .CNT_W      (8),
        .RED_CYC    (RC),
        .GREEN_CYC  (GC),
        .YELLOW_CYC (YC),
        .GREEN_MIN  (GM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: phase codes 0 none, 1 red, 2 green, 3 yellow.
    int cyc      = 0;
    int m_prev   = 0;
    int m_start  = 0;
    bit m_done   = 1'b0;
    bit m_pend   = 1'b0;
    int m_pend_at = 0;
    bit m_walk   = 1'b0;
    bit e_adv    = 1'b0;
    bit e_err    = 1'b0;
    bit e_ack    = 1'b0;
    bit e_walk   = 1'b0;

    // Observations of the most recent cycle plus running totals.
    bit obs_adv  = 1'b0;
    bit obs_ack  = 1'b0;
    bit obs_walk = 1'b0;
    int n_adv    = 0;
    int n_err    = 0;
    int n_walk   = 0;

    // Light FSM used as stimulus.
    int fsm       = 1;
    int run       = 0;
    bit check_len = 1'b0;
    logic [2:0] bad_pat [5];

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic r, input logic y, input logic g);
        if (int'(r) + int'(y) + int'(g) != 1) return 0;
        if (r) return 1;
        if (g) return 2;
        return 3;
    endfunction

    function automatic int dur_of(input int ph);
        case (ph)
            1:       return RC;
            2:       return GC;
            3:       return YC;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_prev = 0; m_done = 1'b0; m_pend = 1'b0; m_walk = 1'b0;
        e_adv = 1'b0; e_err = 1'b0; e_ack = 1'b0; e_walk = 1'b0;
    endtask

    // Predict outputs of cycle cyc+1 from the inputs of cycle cyc.
    task automatic model_update(input logic r, input logic y, input logic g, input logic pr);
        int ph;
        int target;
        int early_at;
        bit new_pend;
        ph = dec(r, y, g);
        e_adv = 1'b0;
        if (ph == 0) begin
            e_err  = 1'b1;
            m_done = 1'b0;
        end else begin
            e_err = 1'b0;
            if (ph != m_prev) begin
                m_start = cyc;
                m_done  = 1'b0;
            end
            target = m_start + dur_of(ph) - 1;
`ifdef PED_REQ_EN
            if (ph == 2 && m_pend) begin
                early_at = (m_start + GM - 1 > m_pend_at + 1) ? m_start + GM - 1 : m_pend_at + 1;
                if (early_at < target) target = early_at;
            end
`endif
            if (!m_done && cyc + 1 == target) begin
                e_adv  = 1'b1;
                m_done = 1'b1;
            end
        end
`ifdef PED_REQ_EN
        e_ack  = pr && !m_pend;
        e_walk = (ph == 1) ? ((m_prev != 1) ? m_pend : m_walk) : 1'b0;
        m_walk = e_walk;
        new_pend = (ph == 1 && m_prev != 1) ? pr : (m_pend || pr);
        if (new_pend && !m_pend) m_pend_at = cyc + 1;
        m_pend = new_pend;
`endif
        m_prev = ph;
    endtask

    task automatic check_outputs();
        check($sformatf("advance@%0d", cyc), bus.advance, e_adv);
        check($sformatf("phase_err@%0d", cyc), bus.phase_err, e_err);
`ifdef PED_REQ_EN
        check($sformatf("ped_ack@%0d", cyc), bus.ped_ack, e_ack);
        check($sformatf("walk@%0d", cyc), bus.walk, e_walk);
`endif
    endtask

    // One cycle: inputs driven just after the rising edge, outputs checked on
    // the falling edge, model advanced on the next rising edge.
    task automatic tick(input logic r, input logic y, input logic g, input logic pr);
        bus.red = r; bus.yellow = y; bus.green = g;
`ifdef PED_REQ_EN
        bus.ped_req = pr;
        obs_ack  = bus.ped_ack;
        obs_walk = bus.walk;
`endif
        @(negedge clk);
        check_outputs();
        obs_adv = bus.advance;
`ifdef PED_REQ_EN
        obs_ack  = bus.ped_ack;
        obs_walk = bus.walk;
        n_walk += int'(obs_walk);
`endif
        n_adv += int'(obs_adv);
        n_err += int'(bus.phase_err);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update(r, y, g, pr);
        cyc++;
        #1;
    endtask

    task automatic clear_counts();
        n_adv = 0; n_err = 0; n_walk = 0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_advance"}, bus.advance, 1'b0);
        check({tag, "_phase_err"}, bus.phase_err, 1'b0);
`ifdef PED_REQ_EN
        check({tag, "_ped_ack"}, bus.ped_ack, 1'b0);
        check({tag, "_walk"}, bus.walk, 1'b0);
`endif
        model_reset();
    endtask

    task automatic fsm_tick(input logic pr, input int stall_pct, input int err_pct);
        logic [2:0] pat;
        pat = {fsm == 1, fsm == 3, fsm == 2};
        if (err_pct > 0 && $urandom_range(99) < err_pct) pat = bad_pat[$urandom_range(4)];
        tick(pat[2], pat[1], pat[0], pr);
        run++;
        if (obs_adv && $urandom_range(99) >= stall_pct) begin
            if (check_len) check_int($sformatf("dwell_ph%0d@%0d", fsm, cyc), run, dur_of(fsm));
            fsm = (fsm == 3) ? 1 : fsm + 1;
            run = 0;
        end
    endtask

    // Runs green until the first advance; returns its cycle offset or -1.
    task automatic green_dwell(input int budget, output int first);
        first = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_adv && first < 0) first = i;
        end
    endtask

    initial begin
        int first;
        int seen;
        bad_pat[0] = 3'b000; bad_pat[1] = 3'b110; bad_pat[2] = 3'b101;
        bad_pat[3] = 3'b011; bad_pat[4] = 3'b111;
        bus.red = 1'b0; bus.yellow = 1'b0; bus.green = 1'b0;
`ifdef PED_REQ_EN
        bus.ped_req = 1'b0;
`endif

        // Reset held with red present, then release: red dwell and stall.
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_counts();
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (obs_adv && first < 0) first = i;
        end
        check_int("red_first_advance", first, RC - 1);
        check_int("red_stall_advances", n_adv, 1);

        // Green after the stalled red restarts the count.
        green_dwell(10, first);
        check_int("green_after_stall", first, GC - 1);

        // Full loop with the light FSM stepping on every advance.
        fsm = 3; run = 0; check_len = 1'b1;
        clear_counts();
        repeat (36) fsm_tick(1'b0, 0, 0);
        check_len = 1'b0;
        check_int("loop_advances", n_adv, 3 * 3);

        // Invalid lamp pattern for two cycles, then green.
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
        clear_counts();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        green_dwell(8, first);
        check_int("invalid_err_cycles", n_err, 2);
        check_int("invalid_advances", n_adv, 1);
        check_int("green_after_invalid", first, GC - 1);

        // Async reset at green count 3 while phase_err is also exercised.
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        async_reset("rst_on_err");
        repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
        async_reset("rst_green3");
        repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        green_dwell(8, first);
        check_int("green_after_reset", first, GC - 1);

`ifdef PED_REQ_EN
        // Request on green entry, a second one while pending, then walk on red.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("ped_no_early_ack", obs_ack, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("ped_ack_next_cycle", obs_ack, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("ped_second_req_no_ack", obs_ack, 1'b0);
        check("ped_early_advance", obs_adv, 1'b1);
        fsm = 3; run = 0; check_len = 1'b1;
        clear_counts();
        repeat (8) fsm_tick(1'b0, 0, 0);
        check_len = 1'b0;
        check_int("ped_walk_cycles", n_walk, RC);

        // Reset while walk is showing.
        fsm_tick(1'b1, 0, 0);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            fsm_tick(1'b0, 0, 0);
            if (obs_walk) seen = 1;
        end
        check_int("walk_reached", seen, 1);
        async_reset("rst_on_walk");
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
`endif

        // Randomized run: stalls, pedestrian requests and bad patterns.
        run = 0;
        for (int i = 0; i < 3000; i++) fsm_tick($urandom_range(99) < 8, 25, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
